perceptron_trainer: RTL and testbench



---
 rtl/perceptron_pkg.sv | 35 +++
 rtl/weight_sat_update.sv | 32 +++
 rtl/perceptron_trainer.sv | 197 +++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron weight trainer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package perceptron_pkg;

    // Trainer sequencer: fetch row, compute update, write row back.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CALC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Default geometry of the predictor this trainer serves.
    localparam int DEF_HIST_LEN = 8;
    localparam int DEF_WEIGHT_W = 8;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_THETA    = 29;
    localparam int DEF_SUM_W    = 13;

    // Saturation limits for the default weight width.
    localparam int WEIGHT_MAX = (1 << (DEF_WEIGHT_W - 1)) - 1;
    localparam int WEIGHT_MIN = -(1 << (DEF_WEIGHT_W - 1));

    // Largest positive value of a signed weight of width w.
    function automatic int weight_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative value of a signed weight of width w.
    function automatic int weight_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/weight_sat_update.sv
// Moves one signed weight by +1 or -1, clamping at the representable limits.
// Latency: purely combinational.
// Backpressure: none; always produces a result.
module weight_sat_update
    import perceptron_pkg::*;
#(
    parameter int WEIGHT_W = DEF_WEIGHT_W
) (
    input  logic [WEIGHT_W-1:0] weight,
    input  logic                inc,
    output logic [WEIGHT_W-1:0] weight_next
);

    localparam logic [WEIGHT_W-1:0] W_MAX = WEIGHT_W'(weight_max(WEIGHT_W));
    localparam logic [WEIGHT_W-1:0] W_MIN = WEIGHT_W'(weight_min(WEIGHT_W));
    localparam logic [WEIGHT_W-1:0] W_ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};

    // Step toward the requested direction unless already pinned at that rail.
    always_comb begin
        weight_next = weight;
        if (inc) begin
            if (weight != W_MAX) begin
                weight_next = weight + W_ONE;
            end
        end else begin
            if (weight != W_MIN) begin
                weight_next = weight - W_ONE;
            end
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: queues resolved branches, read-modify-writes the weight row when training is needed.
// Latency: accept at edge N -> READ after N+1, CALC after N+2, wr_en in the cycle after edge N+3.
// Backpressure: 2-entry request FIFO; req_ready drops while it is full; one row update in flight at a time.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int HIST_LEN = DEF_HIST_LEN,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int THETA    = DEF_THETA,
    parameter int SUM_W    = DEF_SUM_W,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int ROW_W      = (HIST_LEN + 1) * WEIGHT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_idx,
    input  logic [HIST_LEN-1:0]   req_hist,
    input  logic                  req_taken,
    input  logic                  req_pred,
    input  logic [SUM_W-1:0]      req_sum,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ROW_W-1:0]      rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ROW_W-1:0]      wr_data,
    output logic                  busy,
    output logic [15:0]           train_count
);

    localparam logic [1:0]     FIFO_FULL = 2'd2;
    localparam logic [SUM_W:0] THETA_EXT = (SUM_W + 1)'(THETA);

    // ------------------------------------------------------------------
    // Request FIFO (two entries, field-per-array storage)
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] fifo_idx   [2];
    logic [HIST_LEN-1:0]   fifo_hist  [2];
    logic                  fifo_taken [2];
    logic                  fifo_pred  [2];
    logic [SUM_W-1:0]      fifo_sum   [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;
    logic                  push;
    logic                  pop;

    state_t state;
    state_t state_next;

    // Ready depends only on occupancy, so a full FIFO refuses even when a pop is due this cycle.
    assign req_ready = (fifo_cnt != FIFO_FULL);
    assign push      = req_valid && req_ready;
    // The head is retired once its update has been computed.
    assign pop       = (state == ST_CALC);

    // FIFO pointers and occupancy; cleared by reset so in-flight requests are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO payload storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr]   <= req_idx;
            fifo_hist[wr_ptr]  <= req_hist;
            fifo_taken[wr_ptr] <= req_taken;
            fifo_pred[wr_ptr]  <= req_pred;
            fifo_sum[wr_ptr]   <= req_sum;
        end
    end

    logic [ADDR_WIDTH-1:0] head_idx;
    logic [HIST_LEN-1:0]   head_hist;
    logic                  head_taken;
    logic                  head_pred;
    logic [SUM_W-1:0]      head_sum;

    assign head_idx   = fifo_idx[rd_ptr];
    assign head_hist  = fifo_hist[rd_ptr];
    assign head_taken = fifo_taken[rd_ptr];
    assign head_pred  = fifo_pred[rd_ptr];
    assign head_sum   = fifo_sum[rd_ptr];

    // ------------------------------------------------------------------
    // Training decision and weight update
    // ------------------------------------------------------------------
    logic [SUM_W:0]    sum_ext;
    logic [SUM_W:0]    abs_sum;
    logic              train_req;
    logic [HIST_LEN:0] inc_vec;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  new_row;

    // One extra bit keeps |most-negative sum| representable.
    assign sum_ext   = {head_sum[SUM_W-1], head_sum};
    assign abs_sum   = sum_ext[SUM_W] ? (-sum_ext) : sum_ext;
    assign train_req = (head_taken != head_pred) || (abs_sum <= THETA_EXT);

    // Bias follows the outcome; w_i rises when x_i (hist bit as +/-1) matches the outcome.
    assign inc_vec = {~(head_hist ^ {HIST_LEN{head_taken}}), head_taken};

    for (genvar i = 0; i <= HIST_LEN; i++) begin : g_weight
        weight_sat_update #(
            .WEIGHT_W (WEIGHT_W)
        ) u_sat (
            .weight      (row_q[i*WEIGHT_W +: WEIGHT_W]),
            .inc         (inc_vec[i]),
            .weight_next (new_row[i*WEIGHT_W +: WEIGHT_W])
        );
    end

    // Capture the table row at the end of READ so CALC works from a stable copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
        end else if (state == ST_READ) begin
            row_q <= rd_data;
        end
    end

    // Register the write-back address/data when CALC decides an update is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if ((state == ST_CALC) && train_req) begin
            wr_addr <= head_idx;
            wr_data <= new_row;
        end
    end

    // Count completed write-backs; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            train_count <= 16'd0;
        end else if (state == ST_WRITE) begin
            train_count <= train_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------

    // State register; reset returns to IDLE even in the middle of a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: only one request is processed at a time, which serialises same-row updates.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fifo_cnt != 2'd0) state_next = ST_READ;
            ST_READ:  state_next = ST_CALC;
            ST_CALC:  state_next = train_req ? ST_WRITE : ST_IDLE;
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs: table read address, write strobe, busy flag.
    always_comb begin
        rd_addr = '0;
        wr_en   = 1'b0;
        busy    = (state != ST_IDLE) || (fifo_cnt != 2'd0);
        case (state)
            ST_READ:  rd_addr = head_idx;
            ST_WRITE: wr_en   = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
module tb_perceptron_trainer;

    localparam int HL    = 8;
    localparam int WW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RW    = (HL + 1) * WW;
    localparam int SW    = 13;
    localparam int THETA = 29;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_idx;
    logic [HL-1:0] req_hist;
    logic          req_taken;
    logic          req_pred;
    logic [SW-1:0] req_sum;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;
    logic          busy;
    logic [15:0]   train_count;

    perceptron_trainer dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_idx     (req_idx),
        .req_hist    (req_hist),
        .req_taken   (req_taken),
        .req_pred    (req_pred),
        .req_sum     (req_sum),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .train_count (train_count)
    );

    always #5 clk = ~clk;

    // Weight table seen by the DUT, and the bench's in-order reference copy.
    logic [RW-1:0] tb_mem    [DEPTH];
    logic [RW-1:0] model_tbl [DEPTH];
    logic          load_all = 1'b0;

    assign rd_data = tb_mem[rd_addr];

    always @(posedge clk) begin
        if (wr_en) begin
            tb_mem[wr_addr] <= wr_data;
        end else if (load_all) begin
            for (int r = 0; r < DEPTH; r++) tb_mem[r] <= model_tbl[r];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  exp_train = 0;
    int  last_wr_cyc = 0;

    function automatic void check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: train on a misprediction or a low-confidence sum.
    function automatic bit model_train(input bit taken, input bit pred, input int sum_v);
        int mag;
        mag = (sum_v < 0) ? -sum_v : sum_v;
        return (taken != pred) || (mag <= THETA);
    endfunction

    // Reference: bias follows outcome, w_i follows agreement of x_i with outcome, clamp to range.
    function automatic logic [RW-1:0] model_update(input logic [RW-1:0] row, input logic [HL-1:0] hist, input bit taken);
        logic [RW-1:0] r;
        r = row;
        for (int i = 0; i <= HL; i++) begin
            logic [WW-1:0] wb;
            int w;
            int t;
            int xi;
            wb = row[i*WW +: WW];
            w  = int'($signed(wb));
            t  = taken ? 1 : -1;
            if (i == 0) begin
                w = w + t;
            end else begin
                xi = hist[i-1] ? 1 : -1;
                w  = w + ((xi == t) ? 1 : -1);
            end
            if (w > 127)  w = 127;
            if (w < -128) w = -128;
            r[i*WW +: WW] = w[WW-1:0];
        end
        return r;
    endfunction

    // Monitor: every write strobe must match the oldest expected update.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("write_expected", RW'(exp_q.size()), RW'(1));
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", RW'(wr_addr), RW'(mon_e.addr));
                check("wr_data", wr_data, mon_e.data);
            end
        end
    end

    task automatic set_tables(input logic [WW-1:0] fill, input bit rnd);
        for (int r = 0; r < DEPTH; r++)
            for (int k = 0; k <= HL; k++)
                model_tbl[r][k*WW +: WW] = rnd ? WW'($urandom) : fill;
        @(negedge clk);
        load_all = 1'b1;
        @(negedge clk);
        load_all = 1'b0;
    endtask

    task automatic send(input int idx, input int hist, input bit taken, input bit pred, input int sum_v,
                        output int waited, output int acc_c);
        @(negedge clk);
        req_idx   = AW'(idx);
        req_hist  = HL'(hist);
        req_taken = taken;
        req_pred  = pred;
        req_sum   = SW'(sum_v);
        req_valid = 1'b1;
        waited    = 0;
        acc_c     = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("accept", RW'(req_ready), RW'(1));
        if (req_ready) begin
            acc_c = cyc;
            @(posedge clk);
            if (model_train(taken, pred, sum_v)) begin
                model_tbl[idx] = model_update(model_tbl[idx], HL'(hist), taken);
                exp_q.push_back('{addr: AW'(idx), data: model_tbl[idx]});
                exp_train++;
            end
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", RW'(ok), RW'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int a;
        bit seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_idx   = '0;
        req_hist  = '0;
        req_taken = 1'b0;
        req_pred  = 1'b0;
        req_sum   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wr_en",   RW'(wr_en), RW'(0));
        check("rst_wr_addr", RW'(wr_addr), RW'(0));
        check("rst_wr_data", wr_data, RW'(0));
        check("rst_rd_addr", RW'(rd_addr), RW'(0));
        check("rst_count",   RW'(train_count), RW'(0));
        check("rst_busy",    RW'(busy), RW'(0));
        check("rst_ready",   RW'(req_ready), RW'(1));
        reset = 1'b0;

        // Single mispredict on a zero row; latency of the write strobe
        set_tables(8'h00, 1'b0);
        send(3, 8'h01, 1'b1, 1'b0, 0, w, a);
        wait_idle();
        check("lat_write", RW'(last_wr_cyc - a), RW'(4));
        check("row3", tb_mem[3], 72'hFFFFFFFFFFFFFF0101);
        check("count_1", RW'(train_count), RW'(1));

        // Saturated-high row, correct but low-confidence prediction
        set_tables(8'h7F, 1'b0);
        send(9, 8'hFF, 1'b1, 1'b1, 0, w, a);
        wait_idle();
        check("row9_sat", tb_mem[9], 72'h7F7F7F7F7F7F7F7F7F);
        check("count_2", RW'(train_count), RW'(2));

        // Confident correct prediction: no write
        send(4, 8'h3C, 1'b1, 1'b1, 40, w, a);
        wait_idle();
        check("count_conf", RW'(train_count), RW'(2));
        check("busy_conf", RW'(busy), RW'(0));
        check("row4_kept", tb_mem[4], 72'h7F7F7F7F7F7F7F7F7F);

        // Threshold boundaries, including the most negative sum
        send(12, 8'h5A, 1'b0, 1'b0, 29, w, a);
        send(12, 8'h5A, 1'b0, 1'b0, 30, w, a);
        send(12, 8'h5A, 1'b0, 1'b0, -29, w, a);
        send(12, 8'h5A, 1'b0, 1'b0, -30, w, a);
        send(12, 8'h5A, 1'b0, 1'b0, -4096, w, a);
        send(12, 8'h5A, 1'b0, 1'b0, 4095, w, a);
        wait_idle();
        check("count_theta", RW'(train_count), RW'(exp_train & 16'hFFFF));
        check("count_theta_abs", RW'(train_count), RW'(4));

        // Saturated-low row, not-taken outcome
        set_tables(8'h80, 1'b0);
        send(6, 8'h00, 1'b0, 1'b1, 0, w, a);
        wait_idle();
        check("row6_sat", tb_mem[6], 72'h818181818181818180);

        // Three back-to-back requests to one row
        set_tables(8'h00, 1'b0);
        send(5, 8'h0F, 1'b1, 1'b0, 0, w, a);
        send(5, 8'h0F, 1'b1, 1'b0, 0, w, a);
        send(5, 8'h0F, 1'b1, 1'b1, 100, w, a);
        check("ready_low", RW'(w > 0), RW'(1));
        wait_idle();
        check("row5_chain", tb_mem[5], 72'hFEFEFEFE0202020202);
        check("count_chain", RW'(train_count), RW'(7));

        // Randomised traffic against the reference table
        set_tables(8'h00, 1'b1);
        for (int n = 0; n < 300; n++) begin
            int sv;
            if ($urandom_range(0, 1) == 0) sv = int'($urandom_range(0, 80)) - 40;
            else                           sv = int'($urandom_range(0, 8191)) - 4096;
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 1'($urandom), 1'($urandom), sv, w, a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        check("count_rand", RW'(train_count), RW'(exp_train & 16'hFFFF));
        for (int r = 0; r < 8; r++) check("rand_row", tb_mem[r], model_tbl[r]);

        // Reset during WRITE with a second request still queued
        set_tables(8'h10, 1'b0);
        send(2, 8'hAA, 1'b1, 1'b0, 0, w, a);
        send(7, 8'h55, 1'b0, 1'b1, 0, w, a);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (wr_en) begin
                seen = 1'b1;
                break;
            end
        end
        check("midrst_wr_seen", RW'(seen), RW'(1));
        #1;
        reset = 1'b1;
        #1;
        check("midrst_wr_en", RW'(wr_en), RW'(0));
        check("midrst_count", RW'(train_count), RW'(0));
        check("midrst_ready", RW'(req_ready), RW'(1));
        check("midrst_busy",  RW'(busy), RW'(0));
        check("midrst_wdata", wr_data, RW'(0));
        exp_q.delete();
        exp_train = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_row2", tb_mem[2], 72'h101010101010101010);
        check("midrst_row7", tb_mem[7], 72'h101010101010101010);
        check("midrst_count2", RW'(train_count), RW'(0));
        check("midrst_idle", RW'(busy), RW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
